// File: rtl/ppt_pkg.sv
// Shared types and constants for the PPT pulse-train engine and its register map.
package ppt_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ADDR_PERIOD_H     = 4'h0;
  localparam logic [3:0] ADDR_PERIOD_L     = 4'h1;
  localparam logic [3:0] ADDR_WIDTH_H      = 4'h2;
  localparam logic [3:0] ADDR_WIDTH_L      = 4'h3;
  localparam logic [3:0] ADDR_COUNT_H      = 4'h4;
  localparam logic [3:0] ADDR_COUNT_L      = 4'h5;
  localparam logic [3:0] ADDR_RUN          = 4'h7;
  localparam logic [3:0] ADDR_COUNT_DONE_H = 4'h8;
  localparam logic [3:0] ADDR_COUNT_DONE_L = 4'h9;
  localparam logic [3:0] ADDR_DONE         = 4'hA;

endpackage

// File: rtl/ppt_phase_cnt.sv
// Phase counter within one pulse period: sync clear, advance enable, wrap at terminal value.
module ppt_phase_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] phase,
  output logic             wrap
);

  assign wrap = (phase == term);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= wrap ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/ppt_pulse_gen.sv
// Pulse-train engine: run-edge start, shadowed PERIOD/WIDTH/COUNT, period counting and DONE status.
module ppt_pulse_gen
  import ppt_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] count_done_o,
  output logic             cfg_err_o
);

  state_t           state_q, state_d;
  logic             run_q;
  logic [CNT_W-1:0] period_s, width_s, count_s;
  logic [CNT_W-1:0] width_eff, phase, cnt_inc, count_done_d;
  logic             wrap, start, load;
  logic             pulse_d, busy_d, done_d, cfg_err_d;

  assign start     = run_i && !run_q && (state_q == IDLE);
  assign width_eff = (width_s > period_s) ? period_s : width_s;
  assign cnt_inc   = count_done_o + 1'b1;

  ppt_phase_cnt #(.CNT_W(CNT_W)) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clr   (ena_i && start),
    .en    (ena_i && (state_q == RUN) && run_i),
    .term  (period_s - 1'b1),
    .phase (phase),
    .wrap  (wrap)
  );

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    pulse_d      = pulse_o;
    busy_d       = busy_o;
    done_d       = done_o;
    count_done_d = count_done_o;
    cfg_err_d    = cfg_err_o;
    case (state_q)
      IDLE: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          load         = 1'b1;
          count_done_d = '0;
          done_d       = 1'b0;
          if (period_i == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            cfg_err_d = 1'b0;
            busy_d    = 1'b1;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (!run_i) begin
          state_d = IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          pulse_d = (phase < width_eff);
          if (wrap) begin
            count_done_d = cnt_inc;
            // count_s == 0 never matches here, so continuous trains just wrap
            if ((count_s != '0) && (cnt_inc == count_s)) begin
              state_d = DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              pulse_d = 1'b0;
            end
          end
        end
      end
      DONE: begin
        if (!run_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      run_q        <= 1'b0;
      period_s     <= '0;
      width_s      <= '0;
      count_s      <= '0;
      pulse_o      <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      count_done_o <= '0;
      cfg_err_o    <= 1'b0;
    end else if (ena_i) begin
      state_q      <= state_d;
      run_q        <= run_i;
      pulse_o      <= pulse_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      count_done_o <= count_done_d;
      cfg_err_o    <= cfg_err_d;
      if (load) begin
        period_s <= period_i;
        width_s  <= width_i;
        count_s  <= count_i;
      end
    end
  end

endmodule

// File: tb/tb_ppt_pulse_gen.sv
// Scoreboard bench: directed trains push cycle-tagged expectations, a negedge monitor checks them.
module tb_ppt_pulse_gen;

  localparam int unsigned CNT_W = 16;
  localparam int SEL_PULSE = 0, SEL_BUSY = 1, SEL_DONE = 2, SEL_CNT = 3, SEL_CFG = 4, SEL_HI = 5;

  logic             clk = 1'b0;
  logic             rst, ena_i, run_i;
  logic [CNT_W-1:0] period_i, width_i, count_i;
  logic             pulse_o, busy_o, done_o, cfg_err_o;
  logic [CNT_W-1:0] count_done_o;

  ppt_pulse_gen #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena_i        (ena_i),
    .run_i        (run_i),
    .period_i     (period_i),
    .width_i      (width_i),
    .count_i      (count_i),
    .pulse_o      (pulse_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .count_done_o (count_done_o),
    .cfg_err_o    (cfg_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    at;
    string nm;
    int    sel;
    int    val;
    int    base;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   hi_total = 0;
  int   hi_base  = 0;
  int   n_chk    = 0;
  int   n_fail   = 0;
  logic flush    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int observe(input int sel, input int base);
    case (sel)
      SEL_PULSE: return int'(pulse_o);
      SEL_BUSY:  return int'(busy_o);
      SEL_DONE:  return int'(done_o);
      SEL_CNT:   return int'(count_done_o);
      SEL_CFG:   return int'(cfg_err_o);
      default:   return hi_total - base;
    endcase
  endfunction

  // Monitor: counts high cycles, then checks every expectation due at this cycle.
  always @(negedge clk) begin
    exp_t e;
    int   act;
    if (pulse_o === 1'b1) hi_total = hi_total + 1;
    while (sb.size() > 0 && (flush || sb[0].at <= cyc)) begin
      e = sb.pop_front();
      n_chk = n_chk + 1;
      act = observe(e.sel, e.base);
      if (e.at != cyc) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: not checked at cycle %0d (now %0d), got %0d required %0d",
                 e.nm, e.at, cyc, act, e.val);
      end else if (act != e.val) begin
        n_fail = n_fail + 1;
        $display("FAIL %s @cycle %0d: got %0d required %0d", e.nm, cyc, act, e.val);
      end
    end
  end

  function automatic void push_exp(input int at, input string nm, input int sel, input int val);
    exp_t e;
    e.at = at; e.nm = nm; e.sel = sel; e.val = val; e.base = hi_base;
    sb.push_back(e);
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns e0: the cycle index of the edge that sees the run rise.
  task automatic start(input int p, input int w, input int c, output int e0);
    run_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    period_i = CNT_W'(p);
    width_i  = CNT_W'(w);
    count_i  = CNT_W'(c);
    run_i    = 1'b1;
    hi_base  = hi_total;
    e0       = cyc + 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst = 1'b1; ena_i = 1'b1; run_i = 1'b0;
    period_i = '0; width_i = '0; count_i = '0;

    wait_until(2);
    push_exp(2, "rst_pulse", SEL_PULSE, 0);
    push_exp(2, "rst_busy",  SEL_BUSY,  0);
    push_exp(2, "rst_done",  SEL_DONE,  0);
    push_exp(2, "rst_cnt",   SEL_CNT,   0);
    push_exp(2, "rst_cfg",   SEL_CFG,   0);
    wait_until(3);
    rst = 1'b0;

    // nominal P=32 W=4 C=50
    start(32, 4, 50, e0);
    push_exp(e0,        "nom_busy_on",  SEL_BUSY,  1);
    push_exp(e0 + 1,    "nom_pulse_c1", SEL_PULSE, 1);
    push_exp(e0 + 4,    "nom_pulse_c4", SEL_PULSE, 1);
    push_exp(e0 + 5,    "nom_pulse_c5", SEL_PULSE, 0);
    push_exp(e0 + 31,   "nom_cnt_c31",  SEL_CNT,   0);
    push_exp(e0 + 32,   "nom_cnt_c32",  SEL_CNT,   1);
    push_exp(e0 + 32,   "nom_pulse_c32", SEL_PULSE, 0);
    push_exp(e0 + 33,   "nom_pulse_c33", SEL_PULSE, 1);
    push_exp(e0 + 1599, "nom_cnt_c1599", SEL_CNT,  49);
    push_exp(e0 + 1599, "nom_done_c1599", SEL_DONE, 0);
    push_exp(e0 + 1600, "nom_done",     SEL_DONE,  1);
    push_exp(e0 + 1600, "nom_cnt_50",   SEL_CNT,   50);
    push_exp(e0 + 1600, "nom_busy_off", SEL_BUSY,  0);
    push_exp(e0 + 1600, "nom_pulse_end", SEL_PULSE, 0);
    push_exp(e0 + 1600, "nom_hi_cycles", SEL_HI,   200);
    push_exp(e0 + 1605, "nom_hold_done", SEL_DONE, 1);
    push_exp(e0 + 1605, "nom_no_restart", SEL_BUSY, 0);
    wait_until(e0 + 1605);
    run_i = 1'b0;
    push_exp(e0 + 1607, "nom_idle_done", SEL_DONE, 1);
    push_exp(e0 + 1607, "nom_idle_cnt",  SEL_CNT,  50);
    wait_until(e0 + 1607);

    // abort at cycle 100
    start(32, 4, 50, e0);
    push_exp(e0 + 100, "abt_cnt_before", SEL_CNT,  3);
    push_exp(e0 + 100, "abt_busy_before", SEL_BUSY, 1);
    push_exp(e0 + 101, "abt_pulse", SEL_PULSE, 0);
    push_exp(e0 + 101, "abt_busy",  SEL_BUSY,  0);
    push_exp(e0 + 101, "abt_cnt",   SEL_CNT,   3);
    push_exp(e0 + 101, "abt_done",  SEL_DONE,  0);
    wait_until(e0 + 100);
    run_i = 1'b0;
    wait_until(e0 + 101);

    // W=0: restart clears count, no high cycles
    start(8, 0, 4, e0);
    push_exp(e0,      "w0_cnt_clr",  SEL_CNT,  0);
    push_exp(e0 + 8,  "w0_cnt_1",    SEL_CNT,  1);
    push_exp(e0 + 31, "w0_done_c31", SEL_DONE, 0);
    push_exp(e0 + 32, "w0_done",     SEL_DONE, 1);
    push_exp(e0 + 32, "w0_hi",       SEL_HI,   0);
    wait_until(e0 + 32);

    // W>=P: constant high until the completing edge forces low
    start(8, 20, 4, e0);
    push_exp(e0 + 1,  "wbig_c1",   SEL_PULSE, 1);
    push_exp(e0 + 16, "wbig_c16",  SEL_PULSE, 1);
    push_exp(e0 + 31, "wbig_c31",  SEL_PULSE, 1);
    push_exp(e0 + 32, "wbig_end",  SEL_PULSE, 0);
    push_exp(e0 + 32, "wbig_done", SEL_DONE,  1);
    push_exp(e0 + 32, "wbig_hi",   SEL_HI,    31);
    wait_until(e0 + 32);

    // config error then recovery
    start(0, 4, 3, e0);
    push_exp(e0,     "cfg_err_set", SEL_CFG,   1);
    push_exp(e0,     "cfg_busy",    SEL_BUSY,  0);
    push_exp(e0 + 3, "cfg_pulse",   SEL_PULSE, 0);
    push_exp(e0 + 3, "cfg_busy_c3", SEL_BUSY,  0);
    wait_until(e0 + 3);
    start(10, 3, 2, e0);
    push_exp(e0,      "cfg_err_clr",  SEL_CFG,   0);
    push_exp(e0,      "cfg_run_busy", SEL_BUSY,  1);
    push_exp(e0 + 1,  "cfg_run_c1",   SEL_PULSE, 1);
    push_exp(e0 + 3,  "cfg_run_c3",   SEL_PULSE, 1);
    push_exp(e0 + 4,  "cfg_run_c4",   SEL_PULSE, 0);
    push_exp(e0 + 19, "cfg_run_nd",   SEL_DONE,  0);
    push_exp(e0 + 20, "cfg_run_done", SEL_DONE,  1);
    push_exp(e0 + 20, "cfg_run_cnt",  SEL_CNT,   2);
    wait_until(e0 + 20);

    // ena_i low for 10 cycles mid-pulse, then reset mid-run
    start(16, 8, 0, e0);
    push_exp(e0 + 10, "ena_frozen_pulse", SEL_PULSE, 1);
    push_exp(e0 + 10, "ena_frozen_cnt",   SEL_CNT,   0);
    push_exp(e0 + 18, "ena_stretch_hi",   SEL_PULSE, 1);
    push_exp(e0 + 19, "ena_stretch_lo",   SEL_PULSE, 0);
    push_exp(e0 + 25, "ena_cnt_c25",      SEL_CNT,   0);
    push_exp(e0 + 26, "ena_cnt_c26",      SEL_CNT,   1);
    push_exp(e0 + 33, "ena_p2_hi",        SEL_PULSE, 1);
    push_exp(e0 + 40, "rstmid_busy_pre",  SEL_BUSY,  1);
    push_exp(e0 + 41, "rstmid_pulse", SEL_PULSE, 0);
    push_exp(e0 + 41, "rstmid_busy",  SEL_BUSY,  0);
    push_exp(e0 + 41, "rstmid_done",  SEL_DONE,  0);
    push_exp(e0 + 41, "rstmid_cnt",   SEL_CNT,   0);
    push_exp(e0 + 41, "rstmid_cfg",   SEL_CFG,   0);
    wait_until(e0 + 3);
    ena_i = 1'b0;
    wait_until(e0 + 13);
    ena_i = 1'b1;
    wait_until(e0 + 40);
    rst = 1'b1;
    run_i = 1'b0;
    wait_until(e0 + 41);
    rst = 1'b0;

    // continuous with a mid-run PERIOD/WIDTH write that must not take effect
    start(4, 1, 0, e0);
    push_exp(e0 + 5,     "cont_c5",   SEL_PULSE, 1);
    push_exp(e0 + 6,     "cont_c6",   SEL_PULSE, 0);
    push_exp(e0 + 13,    "shadow_c13", SEL_PULSE, 1);
    push_exp(e0 + 14,    "shadow_c14", SEL_PULSE, 0);
    push_exp(e0 + 17,    "shadow_c17", SEL_PULSE, 1);
    push_exp(e0 + 70000, "cont_cnt",  SEL_CNT,   17500);
    push_exp(e0 + 70000, "cont_done", SEL_DONE,  0);
    push_exp(e0 + 70000, "cont_busy", SEL_BUSY,  1);
    wait_until(e0 + 10);
    period_i = 16'd16;
    width_i  = 16'd8;
    wait_until(e0 + 70000);

    flush = 1'b1;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
